// File: rtl/system_clocks.sv
// ---------------------------------------------------------------------------
// system_clocks
//
// Purpose:
//   Digital clock-generation block for the top of the board design. The
//   differential reference clock is divided by an integer ratio and gated to
//   produce two same-frequency clocks at 0 and 180 degrees of phase. A lock
//   timer raises `locked` a fixed number of reference edges after reset
//   release, and the outputs stay low until lock has been observed.
//
// Parameters:
//   DIV         : divide ratio, 1 (pass-through) or an even value 2..256
//   LOCK_CYCLES : reference rising edges from reset release to lock, 1..65535
//
// Ports:
//   clk_in1_p   in   reference clock, positive leg (the block's only clock)
//   clk_in1_n   in   reference clock, negative leg (nominally ~clk_in1_p)
//   reset       in   asynchronous, active-high reset
//   clk_out1    out  generated clock, 0 degree phase
//   clk_out2    out  generated clock, 180 degree phase
//   locked      out  high once both output clocks are stable and valid
//   diff_fault  out  (SYSCLK_DIFF_CHECK_EN only) sticky invalid-pair flag
//
// Build option:
//   SYSCLK_DIFF_CHECK_EN : when defined, clk_in1_n is sampled on every falling
//   edge of clk_in1_p and must read 1. A 0 drops lock and gating, restarts the
//   lock timer and sets diff_fault until the next reset. When undefined,
//   clk_in1_n is ignored and diff_fault does not exist.
// ---------------------------------------------------------------------------
module system_clocks #(
  parameter int DIV         = 1,
  parameter int LOCK_CYCLES = 64
) (
  input  logic clk_in1_p,
  input  logic clk_in1_n,
  input  logic reset,
  output logic clk_out1,
  output logic clk_out2,
  output logic locked
`ifdef SYSCLK_DIFF_CHECK_EN
  ,
  output logic diff_fault
`endif
);

  // Lock is declared on the edge that brings the count to LOCK_CYCLES, i.e.
  // when the pre-increment count equals LOCK_CYCLES-1.
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

  logic [15:0] lock_cnt;
  logic        raw_clk;
  logic        gate_en;
  logic        pair_bad;
  logic        pair_ok;

  // ---- differential-pair monitor (falling edge of clk_in1_p) --------------
`ifdef SYSCLK_DIFF_CHECK_EN
  always_ff @(negedge clk_in1_p or posedge reset) begin
    if (reset) begin
      pair_bad   <= 1'b0;
      diff_fault <= 1'b0;
    end else begin
      pair_bad <= ~clk_in1_n;
      if (!clk_in1_n) begin
        diff_fault <= 1'b1;
      end
    end
  end

  assign pair_ok = clk_in1_n;
`else
  logic unused_clk_in1_n;
  assign unused_clk_in1_n = clk_in1_n;
  assign pair_bad         = 1'b0;
  assign pair_ok          = 1'b1;
`endif

  // ---- lock timer (rising edge of clk_in1_p) -------------------------------
  // The counter only advances while unlocked, so it saturates at LOCK_CYCLES.
  // A bad pair sample from the preceding falling edge restarts the timer.
  always_ff @(posedge clk_in1_p or posedge reset) begin
    if (reset) begin
      lock_cnt <= 16'd0;
      locked   <= 1'b0;
    end else if (pair_bad) begin
      lock_cnt <= 16'd0;
      locked   <= 1'b0;
    end else if (!locked) begin
      lock_cnt <= lock_cnt + 16'd1;
      if (lock_cnt == LOCK_LAST) begin
        locked <= 1'b1;
      end
    end
  end

  // ---- divider (rising edge of clk_in1_p) ----------------------------------
  generate
    if (DIV == 1) begin : g_pass
      assign raw_clk = clk_in1_p;
    end else begin : g_div
      // Toggle every DIV/2 edges for a 50% duty cycle at DIV x T_in.
      localparam logic [7:0] HALF_LAST = 8'(DIV / 2 - 1);

      logic [7:0] div_cnt;
      logic       tog;

      always_ff @(posedge clk_in1_p or posedge reset) begin
        if (reset) begin
          div_cnt <= 8'd0;
          tog     <= 1'b0;
        end else if (div_cnt == HALF_LAST) begin
          div_cnt <= 8'd0;
          tog     <= ~tog;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end

      assign raw_clk = tog;
    end
  endgenerate

  // ---- output gate (falling edge of clk_in1_p) -----------------------------
  // Updating the enable while clk_in1_p is low means it never changes during a
  // high phase of the pass-through clock, so no runt pulse appears on enable.
  // A bad pair sample drops the enable on the same falling edge.
  always_ff @(negedge clk_in1_p or posedge reset) begin
    if (reset) begin
      gate_en <= 1'b0;
    end else begin
      gate_en <= locked & pair_ok;
    end
  end

  // Both outputs share one enable, so they can never be high together and
  // both sit low (clk_out2 not inverted) until the enable is set.
  assign clk_out1 = raw_clk & gate_en;
  assign clk_out2 = ~raw_clk & gate_en;

endmodule

// File: tb/tb_system_clocks.sv
// ---------------------------------------------------------------------------
// tb_system_clocks
//
// Three instances of system_clocks run from one reference clock:
//   u_d1 : DIV=1, LOCK_CYCLES=64
//   u_d4 : DIV=4, LOCK_CYCLES=64
//   u_d2 : DIV=2, LOCK_CYCLES=1
// Each has its own reset. The expected outputs come from an edge-count model:
// k = rising edges since reset release, locked = (k >= LOCK_CYCLES), the
// divided clock is bit 0 of k/(DIV/2), and the gate reflects lock as seen at
// the most recent falling edge.
// ---------------------------------------------------------------------------
module tb_system_clocks;

  localparam int T = 10;

  bit   clk_p;
  bit   clk_n;
  bit   force_n_low;
  logic rst1 = 1'b1;
  logic rst4 = 1'b1;
  logic rst2 = 1'b1;

  logic l1, a1, b1;
  logic l4, a4, b4;
  logic l2, a2, b2;
`ifdef SYSCLK_DIFF_CHECK_EN
  logic f1, f4, f2;
`endif

  int checks = 0;
  int errors = 0;

  system_clocks #(.DIV(1), .LOCK_CYCLES(64)) u_d1 (
    .clk_in1_p(clk_p), .clk_in1_n(clk_n), .reset(rst1),
    .clk_out1(a1), .clk_out2(b1), .locked(l1)
`ifdef SYSCLK_DIFF_CHECK_EN
    , .diff_fault(f1)
`endif
  );

  system_clocks #(.DIV(4), .LOCK_CYCLES(64)) u_d4 (
    .clk_in1_p(clk_p), .clk_in1_n(clk_n), .reset(rst4),
    .clk_out1(a4), .clk_out2(b4), .locked(l4)
`ifdef SYSCLK_DIFF_CHECK_EN
    , .diff_fault(f4)
`endif
  );

  system_clocks #(.DIV(2), .LOCK_CYCLES(1)) u_d2 (
    .clk_in1_p(clk_p), .clk_in1_n(clk_n), .reset(rst2),
    .clk_out1(a2), .clk_out2(b2), .locked(l2)
`ifdef SYSCLK_DIFF_CHECK_EN
    , .diff_fault(f2)
`endif
  );

  // Negative leg settles high slightly before the falling edge of the
  // positive leg so the pair monitor sees a clean value.
  initial begin
    forever begin
      clk_p = 1'b1;
      clk_n = 1'b0;
      #4;
      clk_n = ~force_n_low;
      #1;
      clk_p = 1'b0;
      #5;
    end
  end

  // Reference edge counters since reset release.
  int k1, k4, k2;
  always @(posedge clk_p or posedge rst1) if (rst1) k1 <= 0; else k1 <= k1 + 1;
  always @(posedge clk_p or posedge rst4) if (rst4) k4 <= 0; else k4 <= k4 + 1;
  always @(posedge clk_p or posedge rst2) if (rst2) k2 <= 0; else k2 <= k2 + 1;

  // Edge monitors on generated clocks.
  time rise_t4[$];
  time fall_t4[$];
  int  rise_cnt2;
  always @(posedge a4) rise_t4.push_back($time);
  always @(negedge a4) fall_t4.push_back($time);
  always @(posedge a2) rise_cnt2 <= rise_cnt2 + 1;

  // Expected {locked, clk_out1, clk_out2} for a sample taken in the high
  // (high=1) or low (high=0) phase of the reference clock.
  function automatic logic [2:0] model(int div, int lock, int k, bit high);
    bit lk, gate, raw;
    lk   = (k >= lock);
    gate = high ? ((k - 1) >= lock) : (k >= lock);
    if (div == 1) raw = high;
    else          raw = ((k / (div / 2)) % 2) == 1;
    return {lk, raw & gate, ~raw & gate};
  endfunction

  task automatic test_reset();
    logic [8:0] act;
    rst1 = 1'b1; rst4 = 1'b1; rst2 = 1'b1;
    repeat (5) begin
      @(posedge clk_p); #2;
      act = {l1, a1, b1, l4, a4, b4, l2, a2, b2};
      checks++;
      if (act !== 9'b0) begin
        errors++;
        $display("FAIL reset_high_phase: got %b want %b", act, 9'b0);
      end
      @(negedge clk_p); #2;
      act = {l1, a1, b1, l4, a4, b4, l2, a2, b2};
      checks++;
      if (act !== 9'b0) begin
        errors++;
        $display("FAIL reset_low_phase: got %b want %b", act, 9'b0);
      end
`ifdef SYSCLK_DIFF_CHECK_EN
      checks++;
      if ({f1, f4, f2} !== 3'b0) begin
        errors++;
        $display("FAIL reset_diff_fault: got %b want 000", {f1, f4, f2});
      end
`endif
    end
  endtask

  task automatic test_lock_div1();
    logic [2:0] act, exp;
    rst1 = 1'b0;  // released 2 units after a falling edge
    for (int c = 0; c < 80; c++) begin
      @(posedge clk_p); #2;
      act = {l1, a1, b1}; exp = model(1, 64, k1, 1'b1);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL lock_div1 k=%0d high: got %b want %b", k1, act, exp);
      end
      @(negedge clk_p); #2;
      act = {l1, a1, b1}; exp = model(1, 64, k1, 1'b0);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL lock_div1 k=%0d low: got %b want %b", k1, act, exp);
      end
    end
  endtask

  task automatic test_div4();
    logic [2:0] act, exp;
    rise_t4.delete();
    fall_t4.delete();
    repeat ($urandom_range(1, 6)) @(negedge clk_p);
    #2 rst4 = 1'b0;
    for (int c = 0; c < 90; c++) begin
      @(posedge clk_p); #2;
      act = {l4, a4, b4}; exp = model(4, 64, k4, 1'b1);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL div4 k=%0d high: got %b want %b", k4, act, exp);
      end
      @(negedge clk_p); #2;
      act = {l4, a4, b4}; exp = model(4, 64, k4, 1'b0);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL div4 k=%0d low: got %b want %b", k4, act, exp);
      end
    end
    checks++;
    if (rise_t4.size() < 2 || fall_t4.size() < 1) begin
      errors++;
      $display("FAIL div4_edges: got %0d rises %0d falls want >=2 and >=1",
               rise_t4.size(), fall_t4.size());
    end else begin
      checks++;
      if (fall_t4[0] - rise_t4[0] != 2 * T) begin
        errors++;
        $display("FAIL div4_first_width: got %0t want %0d",
                 fall_t4[0] - rise_t4[0], 2 * T);
      end
      checks++;
      if (rise_t4[1] - rise_t4[0] != 4 * T) begin
        errors++;
        $display("FAIL div4_period: got %0t want %0d",
                 rise_t4[1] - rise_t4[0], 4 * T);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] act, exp;
    repeat ($urandom_range(0, 7)) @(posedge clk_p);
    @(posedge clk_p); #2;
    checks++;
    if ({l1, a1, b1} !== 3'b110) begin
      errors++;
      $display("FAIL async_pre: got %b want 110", {l1, a1, b1});
    end
    rst1 = 1'b1;
    #1;
    checks++;
    if ({l1, a1, b1} !== 3'b000) begin
      errors++;
      $display("FAIL async_drop: got %b want 000", {l1, a1, b1});
    end
    repeat ($urandom_range(1, 4)) @(negedge clk_p);
    #2 rst1 = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk_p); #2;
      act = {l1, a1, b1}; exp = model(1, 64, k1, 1'b1);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL async_relock k=%0d high: got %b want %b", k1, act, exp);
      end
      @(negedge clk_p); #2;
      act = {l1, a1, b1}; exp = model(1, 64, k1, 1'b0);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL async_relock k=%0d low: got %b want %b", k1, act, exp);
      end
    end
  endtask

  task automatic test_short_reset();
    logic [2:0] act, exp;
    @(posedge clk_p); #1;
    rst4 = 1'b1;
    #2 rst4 = 1'b0;
    #1;
    checks++;
    if ({l4, a4, b4} !== 3'b000) begin
      errors++;
      $display("FAIL short_reset_drop: got %b want 000", {l4, a4, b4});
    end
    for (int c = 0; c < 70; c++) begin
      @(negedge clk_p); #2;
      act = {l4, a4, b4}; exp = model(4, 64, k4, 1'b0);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL short_reset k=%0d low: got %b want %b", k4, act, exp);
      end
      @(posedge clk_p); #2;
      act = {l4, a4, b4}; exp = model(4, 64, k4, 1'b1);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL short_reset k=%0d high: got %b want %b", k4, act, exp);
      end
    end
  endtask

  task automatic test_lock1();
    logic [2:0] act, exp;
    @(negedge clk_p); #2;
    rst2 = 1'b0;
    @(posedge clk_p); #2;
    checks++;
    if (l2 !== 1'b1) begin
      errors++;
      $display("FAIL lock1_first_edge: got %b want 1", l2);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_p); #2;
      act = {l2, a2, b2}; exp = model(2, 1, k2, 1'b0);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL lock1 k=%0d low: got %b want %b", k2, act, exp);
      end
      @(posedge clk_p); #2;
      act = {l2, a2, b2}; exp = model(2, 1, k2, 1'b1);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL lock1 k=%0d high: got %b want %b", k2, act, exp);
      end
    end
  endtask

  task automatic test_free_run_div2();
    logic [2:0] act, exp;
    int n, want;
    n = 10000;
    rst2 = 1'b1;
    repeat (2) @(negedge clk_p);
    rise_cnt2 = 0;
    #2 rst2 = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk_p); #2;
      act = {l2, a2, b2}; exp = model(2, 1, k2, 1'b1);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL free_run k=%0d high: got %b want %b", k2, act, exp);
      end
      checks++;
      if (((a1 & b1) | (a4 & b4) | (a2 & b2)) !== 1'b0) begin
        errors++;
        $display("FAIL overlap_high k=%0d: got %b%b %b%b %b%b want no pair 11",
                 k2, a1, b1, a4, b4, a2, b2);
      end
      @(negedge clk_p); #2;
      act = {l2, a2, b2}; exp = model(2, 1, k2, 1'b0);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL free_run k=%0d low: got %b want %b", k2, act, exp);
      end
      checks++;
      if (((a1 & b1) | (a4 & b4) | (a2 & b2)) !== 1'b0) begin
        errors++;
        $display("FAIL overlap_low k=%0d: got %b%b %b%b %b%b want no pair 11",
                 k2, a1, b1, a4, b4, a2, b2);
      end
    end
    want = (n - 1) / 2;
    checks++;
    if (rise_cnt2 < want - 1 || rise_cnt2 > want + 1) begin
      errors++;
      $display("FAIL free_run_rises: got %0d want %0d +/-1", rise_cnt2, want);
    end
  endtask

`ifdef SYSCLK_DIFF_CHECK_EN
  task automatic test_diff_check();
    @(posedge clk_p); #1;
    checks++;
    if ({l1, f1} !== 2'b10) begin
      errors++;
      $display("FAIL diff_pre: got %b want 10", {l1, f1});
    end
    force_n_low = 1'b1;
    @(negedge clk_p); #2;
    force_n_low = 1'b0;
    checks++;
    if ({a1, b1, f1} !== 3'b001) begin
      errors++;
      $display("FAIL diff_event: got %b want 001", {a1, b1, f1});
    end
    @(posedge clk_p); #2;
    checks++;
    if (l1 !== 1'b0) begin
      errors++;
      $display("FAIL diff_unlock: got %b want 0", l1);
    end
    for (int i = 1; i <= 66; i++) begin
      @(posedge clk_p); #2;
      checks++;
      if (l1 !== (i >= 64)) begin
        errors++;
        $display("FAIL diff_relock edge=%0d: got %b want %b", i, l1, (i >= 64));
      end
    end
    checks++;
    if (f1 !== 1'b1) begin
      errors++;
      $display("FAIL diff_sticky: got %b want 1", f1);
    end
    rst1 = 1'b1;
    #1;
    checks++;
    if ({l1, f1} !== 2'b00) begin
      errors++;
      $display("FAIL diff_clear: got %b want 00", {l1, f1});
    end
    @(negedge clk_p); #2 rst1 = 1'b0;
  endtask
`endif

  initial begin
    rise_cnt2   = 0;
    force_n_low = 1'b0;
    test_reset();
    test_lock_div1();
    test_div4();
    test_async_reset();
    test_short_reset();
    test_lock1();
    test_free_run_div2();
`ifdef SYSCLK_DIFF_CHECK_EN
    test_diff_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
